// File: rtl/hub_fwd_arbiter.sv
// -----------------------------------------------------------------------------
// hub_fwd_arbiter
//   Shared forwarding engine for the two-port hub. Both receive deframers offer
//   decoded frame bytes on a valid/ready interface. The arbiter grants one port
//   at a time (round-robin on contention) and serialises the start-frame byte
//   and then the payload bytes, LSB first, onto the tx line of the other port.
//   Every frame is followed by a fixed idle gap before the next grant.
//
// Parameters
//   SFD         start-frame byte sent ahead of every payload (LSB first)
//   GAP_CYCLES  idle tx cycles after each frame, grant still held (>= 1)
//   MAX_BYTES   payload cap; the byte that reaches it closes the frame
//
// Ports
//   clk_i            system clock, rising edge
//   reset_i          synchronous, active-high reset
//   in0_valid_i      port0 byte available
//   in0_data_i[7:0]  port0 payload byte
//   in0_last_i       port0 byte is the final byte of its frame
//   in0_ready_o      port0 byte accepted when valid & ready
//   in1_*            same as in0_*, for port1
//   tx0_o            serial line to port0 (frames sourced by port1)
//   tx1_o            serial line to port1 (frames sourced by port0)
//   grant_o[1:0]     one-hot serializer owner, 2'b00 when idle
//   busy_o           engine is not idle
//   frame_done_o     pulse on the last data bit of a completed frame
//   underrun_o       pulse when a byte was due and the source had none
//   truncated_o      pulse (with frame_done_o) when MAX_BYTES closed the frame
// -----------------------------------------------------------------------------
module hub_fwd_arbiter #(
  parameter logic [7:0]  SFD        = 8'hD5,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned MAX_BYTES  = 64
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       in0_valid_i,
  input  logic [7:0] in0_data_i,
  input  logic       in0_last_i,
  output logic       in0_ready_o,
  input  logic       in1_valid_i,
  input  logic [7:0] in1_data_i,
  input  logic       in1_last_i,
  output logic       in1_ready_o,
  output logic       tx0_o,
  output logic       tx1_o,
  output logic [1:0] grant_o,
  output logic       busy_o,
  output logic       frame_done_o,
  output logic       underrun_o,
  output logic       truncated_o
);

  localparam int CNT_W = $clog2(MAX_BYTES + 1);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BYTES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SFD,
    ST_DATA,
    ST_GAP
  } state_e;

  state_e           state_q,    state_d;
  logic [2:0]       bit_cnt_q,  bit_cnt_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q,  gap_cnt_d;
  logic [7:0]       data_q,     data_d;
  logic             final_q,    final_d;   // byte on the line closes the frame
  logic             trunc_q,    trunc_d;   // ...and it was closed by the cap
  logic             src_q,      src_d;     // 0: port0 is the source, 1: port1
  logic [1:0]       grant_q,    grant_d;
  logic             rr_last_q,  rr_last_d; // port served most recently

  logic             sel_valid;
  logic [7:0]       sel_data;
  logic             sel_last;
  logic             bit7;
  logic             ready_int;
  logic             pick;
  logic             tx_bit;
  logic [CNT_W-1:0] byte_inc;
  logic             cap_hit;

  // Only the granted port's interface is looked at.
  assign sel_valid = src_q ? in1_valid_i : in0_valid_i;
  assign sel_data  = src_q ? in1_data_i  : in0_data_i;
  assign sel_last  = src_q ? in1_last_i  : in0_last_i;

  // A byte is due on the final bit of the SFD and of every non-final byte, so
  // the next byte starts on the following cycle with no bubble.
  assign bit7      = (bit_cnt_q == 3'd7);
  assign ready_int = bit7 && ((state_q == ST_SFD) ||
                              ((state_q == ST_DATA) && !final_q));

  // Saturating byte count; the byte that reaches the cap is the frame's last.
  assign byte_inc = (byte_cnt_q == CNT_MAX) ? byte_cnt_q : byte_cnt_q + CNT_W'(1);
  assign cap_hit  = (byte_inc == CNT_MAX);

  // On contention serve the port not served last; rr_last_q resets to port1
  // so that port0 wins the first contention after reset.
  assign pick = in1_valid_i && (!in0_valid_i || !rr_last_q);

  always_comb begin
    tx_bit = 1'b0;
    if (state_q == ST_SFD) begin
      tx_bit = SFD[bit_cnt_q];
    end else if (state_q == ST_DATA) begin
      tx_bit = data_q[bit_cnt_q];
    end
  end

  // The source's own line stays low; its frame goes out on the other port.
  assign tx0_o        = tx_bit &  src_q;
  assign tx1_o        = tx_bit & ~src_q;
  assign in0_ready_o  = ready_int & grant_q[0];
  assign in1_ready_o  = ready_int & grant_q[1];
  assign underrun_o   = ready_int & ~sel_valid;
  assign frame_done_o = (state_q == ST_DATA) && bit7 && final_q;
  assign truncated_o  = frame_done_o && trunc_q;
  assign grant_o      = grant_q;
  assign busy_o       = (state_q != ST_IDLE);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so that no path
    // through the case leaves one unassigned, which would infer a latch.
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    data_d     = data_q;
    final_d    = final_q;
    trunc_d    = trunc_q;
    src_d      = src_q;
    grant_d    = grant_q;
    rr_last_d  = rr_last_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in0_valid_i || in1_valid_i) begin
          src_d      = pick;
          grant_d    = pick ? 2'b10 : 2'b01;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = '0;
          state_d    = ST_SFD;
        end
      end

      ST_SFD, ST_DATA: begin
        bit_cnt_d = bit_cnt_q + 3'd1;  // wraps 7 -> 0 for the next byte
        if (bit7) begin
          if (ready_int && sel_valid) begin
            data_d     = sel_data;
            final_d    = sel_last || cap_hit;
            trunc_d    = !sel_last && cap_hit;
            byte_cnt_d = byte_inc;
            state_d    = ST_DATA;
          end else begin
            // Either the final byte has been sent or the source underran.
            gap_cnt_d = '0;
            state_d   = ST_GAP;
          end
        end
      end

      ST_GAP: begin
        gap_cnt_d = gap_cnt_q + GAP_W'(1);
        if (gap_cnt_q == GAP_LAST) begin
          grant_d   = 2'b00;
          rr_last_d = src_q;
          state_d   = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset_i) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
      data_q     <= 8'h00;
      final_q    <= 1'b0;
      trunc_q    <= 1'b0;
      src_q      <= 1'b0;
      grant_q    <= 2'b00;
      rr_last_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      data_q     <= data_d;
      final_q    <= final_d;
      trunc_q    <= trunc_d;
      src_q      <= src_d;
      grant_q    <= grant_d;
      rr_last_q  <= rr_last_d;
    end
  end

endmodule
